seg7_count_display: RTL and testbench

Display stage downstream of the 8-bit up/down counter. It takes the counter's binary value and direction, converts the value to three BCD digits with a sequential shift-add-3 engine, and time-multiplexes a 4-digit common-anode 7-segment display. Digit 3 shows the count direction ('U' or 'd'). Digits 2..0 show the decimal value 0..255 with leading-zero blanking.

---
 rtl/seg7_count_display.sv | 158 +++++++++++++++
 tb/tb_seg7_count_display.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_count_display.sv
// Display stage for the up/down counter: synchronises the count, converts it to BCD
// with a sequential shift-add-3 engine and scans a 4-digit common-anode display.
module seg7_count_display #(
   parameter int REFRESH_DIV = 50000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  value,
   input  logic        ud,
   output logic [6:0]  seg,
   output logic [3:0]  an,
   output logic        dp,
   output logic [11:0] bcd,
   output logic        bcd_valid
);

   localparam int RW = $clog2(REFRESH_DIV);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t        state, state_nxt;
   logic [7:0]    s1, s2, last;
   logic          ud1, ud2;
   logic [19:0]   sh, sh_adj;
   logic [2:0]    cnt;
   logic          start;
   logic [RW-1:0] refresh;
   logic [1:0]    idx;
   logic [6:0]    seg_nxt;
   logic [3:0]    an_nxt;

   function automatic logic [6:0] seg_code(input logic [3:0] d);
      case (d)
         4'd0:    return 7'h40;
         4'd1:    return 7'h79;
         4'd2:    return 7'h24;
         4'd3:    return 7'h30;
         4'd4:    return 7'h19;
         4'd5:    return 7'h12;
         4'd6:    return 7'h02;
         4'd7:    return 7'h78;
         4'd8:    return 7'h00;
         4'd9:    return 7'h10;
         default: return 7'h7F;
      endcase
   endfunction

   // A new conversion starts only on a sample seen identically in both sync stages.
   assign start = (s1 == s2) && (s2 != last);
   assign dp    = 1'b1;

   always_comb begin
      sh_adj = sh;
      for (int i = 0; i < 3; i++) begin
         if (sh[8+4*i +: 4] >= 4'd5) sh_adj[8+4*i +: 4] = sh[8+4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SHIFT;
         SHIFT:   if (cnt == 3'd7) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1        <= 8'h00;
         s2        <= 8'h00;
         ud1       <= 1'b0;
         ud2       <= 1'b0;
         last      <= 8'h00;
         sh        <= 20'h0;
         cnt       <= 3'd0;
         bcd       <= 12'h000;
         bcd_valid <= 1'b0;
      end else begin
         s1        <= value;
         s2        <= s1;
         ud1       <= ud;
         ud2       <= ud1;
         bcd_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  last <= s2;
                  sh   <= {12'h000, s2};
                  cnt  <= 3'd0;
               end
            end
            SHIFT: begin
               sh  <= {sh_adj[18:0], 1'b0};
               cnt <= cnt + 3'd1;
            end
            DONE: begin
               bcd       <= sh[19:8];
               bcd_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         refresh <= '0;
         idx     <= 2'd0;
      end else if (refresh == RW'(REFRESH_DIV - 1)) begin
         refresh <= '0;
         idx     <= idx + 2'd1;
      end else begin
         refresh <= refresh + RW'(1);
      end
   end

   // Leading-zero blanking: tens blank only when hundreds is blank too.
   always_comb begin
      seg_nxt = 7'h7F;
      an_nxt  = 4'b1111;
      case (idx)
         2'd0: begin
            an_nxt  = 4'b1110;
            seg_nxt = seg_code(bcd[3:0]);
         end
         2'd1: begin
            an_nxt  = 4'b1101;
            seg_nxt = (bcd[11:4] == 8'h00) ? 7'h7F : seg_code(bcd[7:4]);
         end
         2'd2: begin
            an_nxt  = 4'b1011;
            seg_nxt = (bcd[11:8] == 4'h0) ? 7'h7F : seg_code(bcd[11:8]);
         end
         default: begin
            an_nxt  = 4'b0111;
            seg_nxt = ud2 ? 7'h41 : 7'h21;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         seg <= 7'h7F;
         an  <= 4'b1111;
      end else begin
         seg <= seg_nxt;
         an  <= an_nxt;
      end
   end

endmodule

// File: tb/tb_seg7_count_display.sv
// Bench for seg7_count_display: vector table, hand-written corner sequences and
// random values checked against an arithmetic decimal/segment model.
module tb_seg7_count_display;

   localparam int RD = 4;

   logic        clk;
   logic        reset;
   logic [7:0]  value;
   logic        ud;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic        dp;
   logic [11:0] bcd;
   logic        bcd_valid;

   int n_checks = 0;
   int n_fail   = 0;

   int seg_tab [10] = '{'h40, 'h79, 'h24, 'h30, 'h19, 'h12, 'h02, 'h78, 'h00, 'h10};

   typedef struct {
      logic [7:0]  v;
      logic        u;
      logic [11:0] exp_bcd;
   } vec_t;

   vec_t vecs [5];

   seg7_count_display #(.REFRESH_DIV(RD)) dut (
      .clk       (clk),
      .reset     (reset),
      .value     (value),
      .ud        (ud),
      .seg       (seg),
      .an        (an),
      .dp        (dp),
      .bcd       (bcd),
      .bcd_valid (bcd_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [11:0] to_bcd(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic int model_seg(input logic [3:0] a, input int v, input logic u);
      case (a)
         4'b1110: return seg_tab[v % 10];
         4'b1101: return (v >= 10)  ? seg_tab[(v / 10) % 10] : 'h7F;
         4'b1011: return (v >= 100) ? seg_tab[v / 100] : 'h7F;
         4'b0111: return u ? 'h41 : 'h21;
         default: return -1;
      endcase
   endfunction

   // Returns edges-until-pulse counted in negedges, or -1 on timeout.
   task automatic wait_valid(output int lat);
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (bcd_valid) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic check_scan(input int v, input logic u);
      logic [3:0] mask;
      mask = 4'h0;
      for (int i = 0; i < 4 * RD; i++) begin
         @(negedge clk);
         check("scan seg", 32'(seg), 32'(model_seg(an, v, u)));
         case (an)
            4'b1110: mask[0] = 1'b1;
            4'b1101: mask[1] = 1'b1;
            4'b1011: mask[2] = 1'b1;
            4'b0111: mask[3] = 1'b1;
            default: ;
         endcase
      end
      check("scan all anodes", 32'(mask), 32'hF);
      check("dp off", 32'(dp), 32'h1);
   endtask

   initial begin
      int lat;
      int cur;
      int v;
      logic u;
      logic seen;

      vecs[0] = '{8'd255, 1'b1, 12'h255};
      vecs[1] = '{8'd7,   1'b0, 12'h007};
      vecs[2] = '{8'd70,  1'b0, 12'h070};
      vecs[3] = '{8'd100, 1'b0, 12'h100};
      vecs[4] = '{8'd0,   1'b1, 12'h000};

      reset = 1'b0;
      value = 8'd0;
      ud    = 1'b1;
      repeat (5) @(negedge clk);
      check("reset seg", 32'(seg), 32'h7F);
      check("reset an", 32'(an), 32'hF);
      check("reset bcd", 32'(bcd), 32'h000);
      check("reset valid", 32'(bcd_valid), 32'h0);
      check("reset dp", 32'(dp), 32'h1);
      reset = 1'b1;
      @(negedge clk);
      check("first an", 32'(an), 32'hE);
      check("first seg", 32'(seg), 32'h40);
      check_scan(0, 1'b1);

      for (int k = 0; k < 5; k++) begin
         value = vecs[k].v;
         ud    = vecs[k].u;
         wait_valid(lat);
         check("vec latency", 32'(lat), 32'd12);
         check("vec bcd", 32'(bcd), 32'(vecs[k].exp_bcd));
         @(negedge clk);
         check("vec pulse width", 32'(bcd_valid), 32'h0);
         check_scan(int'(vecs[k].v), vecs[k].u);
      end

      value = 8'h10;
      wait_valid(lat);
      check("pre-glitch bcd", 32'(bcd), 32'h016);
      value = 8'hFF;
      @(negedge clk);
      value = 8'h10;
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (bcd_valid) seen = 1'b1;
      end
      check("glitch no pulse", 32'(seen), 32'h0);
      check("glitch bcd kept", 32'(bcd), 32'h016);

      value = 8'h05;
      repeat (5) @(negedge clk);
      value = 8'hC8;
      wait_valid(lat);
      check("busy first latency", 32'(lat), 32'd7);
      check("busy first bcd", 32'(bcd), 32'h005);
      wait_valid(lat);
      check("busy second within 10", 32'(lat > 0 && lat <= 10), 32'h1);
      check("busy second bcd", 32'(bcd), 32'h200);

      value = 8'h99;
      repeat (6) @(negedge clk);
      reset = 1'b0;
      #1;
      check("midconv bcd", 32'(bcd), 32'h000);
      check("midconv an", 32'(an), 32'hF);
      check("midconv seg", 32'(seg), 32'h7F);
      repeat (3) @(negedge clk);
      check("midconv valid", 32'(bcd_valid), 32'h0);
      reset = 1'b1;
      wait_valid(lat);
      check("restart latency", 32'(lat), 32'd12);
      check("restart bcd", 32'(bcd), 32'h153);
      check_scan(153, ud);

      cur = 153;
      for (int k = 0; k < 12; k++) begin
         v = int'($urandom_range(0, 255));
         u = 1'($urandom_range(0, 1));
         value = 8'(v);
         ud    = u;
         if (v == cur) begin
            seen = 1'b0;
            repeat (14) begin
               @(negedge clk);
               if (bcd_valid) seen = 1'b1;
            end
            check("rand repeat no pulse", 32'(seen), 32'h0);
            check("rand repeat bcd", 32'(bcd), 32'(to_bcd(v)));
         end else begin
            wait_valid(lat);
            check("rand latency", 32'(lat), 32'd12);
            check("rand bcd", 32'(bcd), 32'(to_bcd(v)));
         end
         cur = v;
         check_scan(v, u);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
